// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared state encoding, control codes and cursor width for the text cursor sequencer
package text_pkg;

  localparam int CURSOR_W = 5;

  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ADVANCE   = 3'd4,
    ST_CTRL      = 3'd5
  } state_t;

  function automatic logic is_ctrl_code(input logic [7:0] code);
    return (code == CC_LF) || (code == CC_CR) || (code == CC_BS);
  endfunction

endpackage

// File: rtl/text_cursor_pos.sv
// rtl/text_cursor_pos.sv - text cursor column/row register with wrap, home and control updates, plus pixel mapping
module text_cursor_pos
  import text_pkg::*;
#(
  parameter int CHAR_W   = 24,
  parameter int CHAR_H   = 27,
  parameter int COLS     = 26,
  parameter int ROWS     = 17,
  parameter int ORIGIN_X = 4,
  parameter int ORIGIN_Y = 3
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                home,
  input  logic                advance,
  input  logic                ctrl_lf,
  input  logic                ctrl_cr,
  input  logic                ctrl_bs,
  output logic [CURSOR_W-1:0] col,
  output logic [CURSOR_W-1:0] row,
  output logic [9:0]          pix_x,
  output logic [9:0]          pix_y
);

  localparam logic [CURSOR_W-1:0] LAST_COL = CURSOR_W'(COLS - 1);
  localparam logic [CURSOR_W-1:0] LAST_ROW = CURSOR_W'(ROWS - 1);
  localparam logic [9:0] CW = 10'(CHAR_W);
  localparam logic [9:0] CH = 10'(CHAR_H);
  localparam logic [9:0] OX = 10'(ORIGIN_X);
  localparam logic [9:0] OY = 10'(ORIGIN_Y);

  logic [CURSOR_W-1:0] row_inc;

  // Next row with wrap to the top; the screen never scrolls
  always_comb begin
    row_inc = (row == LAST_ROW) ? '0 : row + 1'b1;
  end

  // Cursor update: home wins, then glyph advance, then control codes
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row_inc;
      end else begin
        col <= col + 1'b1;
      end
    end else if (ctrl_lf) begin
      col <= '0;
      row <= row_inc;
    end else if (ctrl_cr) begin
      col <= '0;
    end else if (ctrl_bs) begin
      col <= (col == '0) ? '0 : col - 1'b1;
    end
  end

  assign pix_x = OX + 10'(col) * CW;
  assign pix_y = OY + 10'(row) * CH;

endmodule

// File: rtl/text_cursor_sequencer.sv
// rtl/text_cursor_sequencer.sv - feeds characters to display_char one glyph at a time; TEXT_CTRL_CHARS_EN enables LF/CR/BS handling
module text_cursor_sequencer
  import text_pkg::*;
#(
  parameter int CHAR_W            = 24,
  parameter int CHAR_H            = 27,
  parameter int COLS              = 26,
  parameter int ROWS              = 17,
  parameter int ORIGIN_X          = 4,
  parameter int ORIGIN_Y          = 3,
  parameter int RASTER_DATA_WIDTH = 16,
  parameter int BUSY_TIMEOUT      = 7
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [7:0]                   in_char,
  input  logic [RASTER_DATA_WIDTH-1:0] in_color,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         home,
  output logic [CURSOR_W-1:0]          cursor_col,
  output logic [CURSOR_W-1:0]          cursor_row,
  output logic [9:0]                   dc_raster_x,
  output logic [9:0]                   dc_raster_y,
  output logic [7:0]                   dc_char_select,
  output logic [RASTER_DATA_WIDTH-1:0] dc_wdata,
  output logic                         dc_start_write,
  input  logic                         dc_busy,
  output logic                         err_timeout
);

  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] to_cnt;
  logic       accept, do_home, do_adv, do_lf, do_cr, do_bs, timeout_hit;
  logic [9:0] pix_x, pix_y;

  text_cursor_pos #(
    .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .COLS(COLS), .ROWS(ROWS),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y)
  ) u_pos (
    .clk(clk), .arst(arst), .home(do_home), .advance(do_adv),
    .ctrl_lf(do_lf), .ctrl_cr(do_cr), .ctrl_bs(do_bs),
    .col(cursor_col), .row(cursor_row), .pix_x(pix_x), .pix_y(pix_y)
  );

  // Next-state and handshake decode
  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    dc_start_write = 1'b0;
    accept         = 1'b0;
    do_home        = 1'b0;
    do_adv         = 1'b0;
    do_lf          = 1'b0;
    do_cr          = 1'b0;
    do_bs          = 1'b0;
    timeout_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !home;
        do_home  = home;
        if (!home && in_valid) begin
          accept = 1'b1;
`ifdef TEXT_CTRL_CHARS_EN
          state_nxt = is_ctrl_code(in_char) ? ST_CTRL : ST_ISSUE;
`else
          state_nxt = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        dc_start_write = 1'b1;
        state_nxt      = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (dc_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_ADVANCE;
        end
      end
      ST_WAIT_DONE: begin
        if (!dc_busy) state_nxt = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        do_adv    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_CTRL: begin
        do_lf     = (dc_char_select == CC_LF);
        do_cr     = (dc_char_select == CC_CR);
        do_bs     = (dc_char_select == CC_BS);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, busy-rise timeout counter and sticky error
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_ISSUE)          to_cnt <= '0;
      else if (state == ST_WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  // Request fields are captured at accept and held until IDLE is re-entered
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dc_raster_x    <= '0;
      dc_raster_y    <= '0;
      dc_char_select <= '0;
      dc_wdata       <= '0;
    end else if (accept) begin
      dc_raster_x    <= pix_x;
      dc_raster_y    <= pix_y;
      dc_char_select <= in_char;
      dc_wdata       <= in_color;
    end
  end

endmodule

// File: tb/tb_text_cursor_sequencer.sv
// tb/tb_text_cursor_sequencer.sv - randomized self-checking bench for text_cursor_sequencer
module tb_text_cursor_sequencer;

  logic        clk = 1'b0;
  logic        arst;
  logic [7:0]  in_char;
  logic [15:0] in_color;
  logic        in_valid;
  logic        in_ready;
  logic        home;
  logic [4:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [9:0]  dc_raster_x;
  logic [9:0]  dc_raster_y;
  logic [7:0]  dc_char_select;
  logic [15:0] dc_wdata;
  logic        dc_start_write;
  logic        dc_busy;
  logic        err_timeout;

  text_cursor_sequencer dut (
    .clk(clk), .arst(arst), .in_char(in_char), .in_color(in_color),
    .in_valid(in_valid), .in_ready(in_ready), .home(home),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .dc_raster_x(dc_raster_x), .dc_raster_y(dc_raster_y),
    .dc_char_select(dc_char_select), .dc_wdata(dc_wdata),
    .dc_start_write(dc_start_write), .dc_busy(dc_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_col   = 0;
  int m_row   = 0;
  bit m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_is_ctrl(input logic [7:0] c);
`ifdef TEXT_CTRL_CHARS_EN
    return (c == 8'h0A) || (c == 8'h0D) || (c == 8'h08);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_advance();
    m_col++;
    if (m_col == 26) begin
      m_col = 0;
      m_row = (m_row + 1) % 17;
    end
  endfunction

  function automatic void model_ctrl(input logic [7:0] c);
    if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 17;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (m_col > 0) begin
      m_col--;
    end
  endfunction

  // Offer one character and act as display_char: busy rises 2 cycles after the
  // start pulse and stays high for blen cycles; blen==0 means busy never rises.
  task automatic send(input logic [7:0] c, input logic [15:0] color, input int blen, input bit with_home);
    int  ex, ey, k, stray, early, held_bad;
    bit  done, err_before;
    @(negedge clk);
    in_char  = c;
    in_color = color;
    in_valid = 1'b1;
    if (with_home) begin
      home = 1'b1;
      #1;
      check("home_blocks_ready", in_ready, 0);
      @(negedge clk);
      home  = 1'b0;
      m_col = 0;
      m_row = 0;
      #1;
      check("home_col", cursor_col, 0);
      check("home_row", cursor_row, 0);
      check("home_no_pulse", dc_start_write, 0);
    end else begin
      #1;
    end
    check("ready_in_idle", in_ready, 1);
    ex = (4 + m_col * 24) % 1024;
    ey = (3 + m_row * 27) % 1024;
    err_before = m_err;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    if (model_is_ctrl(c)) begin
      check("ctrl_no_pulse", dc_start_write, 0);
      check("ctrl_ready_low", in_ready, 0);
      @(negedge clk);
      #1;
      check("ctrl_ready_back", in_ready, 1);
      check("ctrl_no_pulse2", dc_start_write, 0);
      model_ctrl(c);
      check("ctrl_col", cursor_col, m_col);
      check("ctrl_row", cursor_row, m_row);
      return;
    end
    check("pulse_after_accept", dc_start_write, 1);
    check("raster_x", dc_raster_x, ex);
    check("raster_y", dc_raster_y, ey);
    check("char_select", dc_char_select, c);
    check("wdata", dc_wdata, color);
    check("ready_low_busy", in_ready, 0);
    check("err_before", err_timeout, err_before);
    k = 0; stray = 0; early = 0; held_bad = 0; done = 1'b0;
    while (!done && k < 64) begin
      @(negedge clk);
      k++;
      if (blen > 0 && k == 2) dc_busy = 1'b1;
      if (blen > 0 && k == 2 + blen) dc_busy = 1'b0;
      #1;
      if (dc_start_write) stray++;
      if (dc_raster_x !== 10'(ex) || dc_raster_y !== 10'(ey)) held_bad++;
      if (in_ready) begin
        if (dc_busy || (blen > 0 && k < 2 + blen)) early++;
        done = 1'b1;
      end
    end
    dc_busy = 1'b0;
    check("ready_returns", done, 1);
    check("single_pulse", stray, 0);
    check("ready_not_early", early, 0);
    check("fields_held", held_bad, 0);
    model_advance();
    if (blen == 0) m_err = 1'b1;
    check("cursor_col", cursor_col, m_col);
    check("cursor_row", cursor_row, m_row);
    check("err_timeout", err_timeout, m_err);
  endtask

  initial begin
    arst     = 1'b1;
    in_char  = 8'h00;
    in_color = 16'h0000;
    in_valid = 1'b0;
    home     = 1'b0;
    dc_busy  = 1'b0;
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_pulse", dc_start_write, 0);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);
    check("rst_err", err_timeout, 0);
    check("rst_x", dc_raster_x, 0);
    check("rst_y", dc_raster_y, 0);
    check("rst_char", dc_char_select, 0);
    check("rst_wdata", dc_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;

    send(8'h41, 16'hF800, 3, 1'b0);
    check("first_col", cursor_col, 1);

    send(8'h42, 16'h07E0, 2, 1'b1);

    while (m_col != 25) send(8'($urandom_range(32, 126)), 16'($urandom), 1, 1'b0);
    send(8'h5A, 16'h001F, 2, 1'b0);
    check("row_wrap_col", cursor_col, 0);
    check("row_wrap_row", cursor_row, 1);
    send(8'h43, 16'h1234, 1, 1'b0);

    send(8'h44, 16'hABCD, 0, 1'b0);
    check("timeout_sticky", err_timeout, 1);

    @(negedge clk);
    dc_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("spurious_busy_ready", in_ready, 1);
    end
    dc_busy = 1'b0;
    check("spurious_busy_col", cursor_col, m_col);

    send(8'h45, 16'h0F0F, 1, 1'b1);
    while (!(m_col == 5 && m_row == 2)) send(8'($urandom_range(32, 126)), 16'($urandom), 1, 1'b0);
    send(8'h0A, 16'h5555, 2, 1'b0);

    for (int i = 0; i < 460; i++) begin
      logic [7:0] ch;
      ch = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ch = 8'h0A;
      send(ch, 16'($urandom), int'($urandom_range(0, 5)), $urandom_range(0, 39) == 0);
    end

    while (!(m_col == 25 && m_row == 16)) send(8'($urandom_range(32, 126)), 16'($urandom), 1, 1'b0);
    send(8'h46, 16'hFFFF, 1, 1'b0);
    check("screen_wrap_col", cursor_col, 0);
    check("screen_wrap_row", cursor_row, 0);

    send(8'h47, 16'h2222, 1, 1'b0);
    @(negedge clk);
    in_char  = 8'h48;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("midop_pulse_before", dc_start_write, 1);
    arst = 1'b1;
    #1;
    check("midop_pulse_async", dc_start_write, 0);
    check("midop_ready", in_ready, 1);
    check("midop_col", cursor_col, 0);
    check("midop_row", cursor_row, 0);
    check("midop_err", err_timeout, 0);
    @(negedge clk);
    arst  = 1'b0;
    m_col = 0;
    m_row = 0;
    m_err = 1'b0;
    send(8'h49, 16'h3333, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
